ts_stream_switch: RTL and testbench
===================================

// Module: ts_stream_switch
// PURPOSE
//  Packet-aligned 4:1 scheduler behind the four sync-recovery channels. Selects one
//  channel's byte stream onto a single TS output and tracks per-channel lock. Switches
//  channel only on 188-byte packet boundaries, on host request or on automatic failover.
//  The output therefore never carries a partial packet after a switch.
// PARAMETERS
//  LOSS_BYTES  10'd376  valid bytes with no sync on a channel before its lock is dropped
//  AUTO_FAIL   1'b1     1: on loss of the active lock, hunt the next locked channel (round-robin)
// PORTS
//  clk            in   1  system clock
//  rst            in   1  asynchronous reset, active low
//  byte_1..byte_4 in   8  channel data from sync recovery
//  valid_1..4     in   1  channel byte strobe
//  sync_1..4      in   1  high with valid on a locked 0x47 sync byte
//  sel_req        in   2  requested channel (0..3 = channel 1..4)
//  sel_req_valid  in   1  1-cycle strobe that captures sel_req
//  out_byte       out  8  selected TS byte
//  out_valid      out  1  out_byte strobe
//  out_sync       out  1  high with out_valid on each forwarded sync byte
//  active_ch      out  2  channel currently forwarded
//  ch_locked      out  4  per-channel lock flags
//  switch_done    out  1  1-cycle pulse when a new channel's first sync byte is output
//  pkt_abort      out  1  1-cycle pulse when the active channel loses lock mid-packet
// BEHAVIOUR
//  Reset: every output is 0; pending request is cleared; lock counters are 0; FSM = IDLE.
//  Lock tracking, per channel:
//  - valid & sync sets ch_locked and clears the counter.
//  - valid & !sync increments the counter, saturating.
//  - Counter reaching LOSS_BYTES clears ch_locked.
//  Request: sel_req_valid loads pend_ch and sets pend. The latest request wins. A request
//   is visible to the FSM from the cycle after capture.
//  Target: pend_ch if pend; else active_ch; else, if AUTO_FAIL, the first locked channel
//   scanning active_ch+1, +2, +3 (wrapping).
//  FSM:
//  - IDLE: out_valid = 0. Stay while the target is unlocked. When the target is locked,
//    go to WAIT_SOP.
//  - WAIT_SOP: discard target bytes until valid & sync on the target.
//    * That sync byte is forwarded.
//    * active_ch <= target; switch_done = 1.
//    * If pend_ch equals that target, pend is cleared.
//    * Go to FORWARD.
//    * If the target loses lock while waiting, go to IDLE.
//  - FORWARD: every valid byte of active_ch is forwarded.
//    * On a sync byte, if pend and pend_ch != active_ch and ch_locked[pend_ch]: drop this
//      byte and go to WAIT_SOP on pend_ch. Otherwise forward it and clear pend if
//      pend_ch == active_ch.
//    * If active lock drops: pkt_abort = 1. Go to IDLE with no further bytes.
//  Pending request to an unlocked channel: stays pending, and forwarding continues.
//  Datapath latency: exactly one clk from input strobe to out_valid (registered outputs).
//   out_byte is 0 when out_valid = 0.
//  Simultaneous events:
//  - A sync byte on active in the same cycle as sel_req_valid uses the old pend value.
//  - Lock loss and a sync byte in the same cycle: the sync byte wins (relocks).
//  Reset mid-packet: outputs go to 0 immediately; lock is reacquired from scratch.
// TESTING
//  1) Ch1 locked stream, no request -> after the first ch1 sync, out mirrors ch1 with 1-clk
//     latency; active_ch = 0; switch_done pulses once.
//  2) Request ch3 mid-packet of ch1 -> ch1 runs to byte 188. Ch1's next sync is dropped.
//     The output resumes at ch3's sync byte; active_ch = 2; no partial packet.
//  3) Active ch1 stops syncing (0x00 bytes) -> after 376 bytes: pkt_abort pulses,
//     ch_locked[0] = 0. With ch2 locked and AUTO_FAIL = 1, the output resumes at ch2's sync.
//  4) Request ch4 while ch4 is unlocked -> ch1 continues. ch4 locks later -> switch at the
//     next ch1 boundary.
//  5) Two requests (ch2, then ch4) within one packet -> switch goes to ch4 only.
//  6) Reset asserted mid-FORWARD -> all outputs 0 in the same cycle; normal reacquire
//     after release.

Source files
------------

// File: rtl/ts_stream_switch.sv
// Packet-aligned 4:1 TS stream scheduler with per-channel lock tracking.
// Channel changes happen only on 188-byte packet boundaries (host request or failover).
module ts_stream_switch #(
  parameter logic [9:0] LOSS_BYTES = 10'd376,
  parameter bit         AUTO_FAIL  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_1,
  input  logic [7:0] byte_2,
  input  logic [7:0] byte_3,
  input  logic [7:0] byte_4,
  input  logic       valid_1,
  input  logic       valid_2,
  input  logic       valid_3,
  input  logic       valid_4,
  input  logic       sync_1,
  input  logic       sync_2,
  input  logic       sync_3,
  input  logic       sync_4,
  input  logic [1:0] sel_req,
  input  logic       sel_req_valid,
  output logic [7:0] out_byte,
  output logic       out_valid,
  output logic       out_sync,
  output logic [1:0] active_ch,
  output logic [3:0] ch_locked,
  output logic       switch_done,
  output logic       pkt_abort
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_SOP = 2'd1,
    S_FORWARD  = 2'd2
  } state_t;

  logic [7:0]       w_byte  [N_CH];
  logic [N_CH-1:0]  w_valid;
  logic [N_CH-1:0]  w_sync;
  logic [CNT_W-1:0] r_cnt   [N_CH];
  logic [CNT_W-1:0] w_cnt_inc [N_CH];
  logic [N_CH-1:0]  r_locked;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_tgt, w_tgt_nxt;
  logic [1:0] r_active, w_active_nxt;
  logic       r_pend;
  logic [1:0] r_pend_ch;
  logic       w_pend_clr;
  logic [1:0] w_target;
  logic [1:0] w_scan_ch;
  logic       w_scan_hit;

  logic       w_fwd, w_fwd_sync, w_switch, w_abort;
  logic [7:0] w_fwd_byte;
  logic [7:0] r_out_byte;
  logic       r_out_valid, r_out_sync, r_switch_done, r_pkt_abort;

  assign w_byte[0] = byte_1;
  assign w_byte[1] = byte_2;
  assign w_byte[2] = byte_3;
  assign w_byte[3] = byte_4;
  assign w_valid   = {valid_4, valid_3, valid_2, valid_1};
  assign w_sync    = {sync_4, sync_3, sync_2, sync_1} & w_valid;

  // Saturating count of valid bytes since the last sync, per channel
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_cnt_inc[i] = (r_cnt[i] >= LOSS_BYTES) ? r_cnt[i] : r_cnt[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) r_cnt[i] <= '0;
      r_locked <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_sync[i]) begin
          r_locked[i] <= 1'b1;
          r_cnt[i]    <= '0;
        end else if (w_valid[i]) begin
          r_cnt[i] <= w_cnt_inc[i];
          if (w_cnt_inc[i] >= LOSS_BYTES) r_locked[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin hunt from active_ch+1; nearest locked channel wins
  always_comb begin
    w_scan_ch  = r_active;
    w_scan_hit = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      if (r_locked[2'(r_active + 2'(k))]) begin
        w_scan_ch  = 2'(r_active + 2'(k));
        w_scan_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_target = r_active;
    if (r_pend)                                  w_target = r_pend_ch;
    else if (r_locked[r_active] || !AUTO_FAIL)   w_target = r_active;
    else if (w_scan_hit)                         w_target = w_scan_ch;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_tgt    <= '0;
      r_active <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tgt    <= w_tgt_nxt;
      r_active <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_tgt_nxt    = r_tgt;
    w_active_nxt = r_active;
    w_fwd        = 1'b0;
    w_fwd_byte   = 8'h00;
    w_fwd_sync   = 1'b0;
    w_switch     = 1'b0;
    w_abort      = 1'b0;
    w_pend_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_locked[w_target]) begin
          w_tgt_nxt   = w_target;
          w_state_nxt = S_WAIT_SOP;
        end
      end
      S_WAIT_SOP: begin
        // A sync byte relocks, so it takes priority over a concurrent lock loss
        if (w_sync[r_tgt]) begin
          w_fwd        = 1'b1;
          w_fwd_byte   = w_byte[r_tgt];
          w_fwd_sync   = 1'b1;
          w_active_nxt = r_tgt;
          w_switch     = 1'b1;
          w_pend_clr   = r_pend && (r_pend_ch == r_tgt);
          w_state_nxt  = S_FORWARD;
        end else if (!r_locked[r_tgt]) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FORWARD: begin
        if (!r_locked[r_active] && !w_sync[r_active]) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_valid[r_active]) begin
          if (w_sync[r_active] && r_pend && (r_pend_ch != r_active) && r_locked[r_pend_ch]) begin
            w_tgt_nxt   = r_pend_ch;
            w_state_nxt = S_WAIT_SOP;
          end else begin
            w_fwd      = 1'b1;
            w_fwd_byte = w_byte[r_active];
            w_fwd_sync = w_sync[r_active];
            w_pend_clr = w_sync[r_active] && r_pend && (r_pend_ch == r_active);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latest host request wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend    <= 1'b0;
      r_pend_ch <= '0;
    end else if (sel_req_valid) begin
      r_pend    <= 1'b1;
      r_pend_ch <= sel_req;
    end else if (w_pend_clr) begin
      r_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_byte    <= 8'h00;
      r_out_valid   <= 1'b0;
      r_out_sync    <= 1'b0;
      r_switch_done <= 1'b0;
      r_pkt_abort   <= 1'b0;
    end else begin
      r_out_byte    <= w_fwd_byte;
      r_out_valid   <= w_fwd;
      r_out_sync    <= w_fwd_sync;
      r_switch_done <= w_switch;
      r_pkt_abort   <= w_abort;
    end
  end

  assign out_byte    = r_out_byte;
  assign out_valid   = r_out_valid;
  assign out_sync    = r_out_sync;
  assign active_ch   = r_active;
  assign ch_locked   = r_locked;
  assign switch_done = r_switch_done;
  assign pkt_abort   = r_pkt_abort;

endmodule

// File: tb/tb_ts_stream_switch.sv
// Directed bench for ts_stream_switch: four 188-byte packet streams with per-channel phase.
module tb_ts_stream_switch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] b1, b2, b3, b4;
  logic       v1, v2, v3, v4;
  logic       s1, s2, s3, s4;
  logic [1:0] sel_req = 2'd0;
  logic       sel_req_valid = 1'b0;
  logic [7:0] out_byte;
  logic       out_valid, out_sync, switch_done, pkt_abort;
  logic [1:0] active_ch;
  logic [3:0] ch_locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit         en [4];
  int         off[4];
  logic [7:0] drv_b[4];
  logic       drv_s[4];
  int         last_p[4];

  ts_stream_switch dut (
    .clk(clk), .rst(rst),
    .byte_1(b1), .byte_2(b2), .byte_3(b3), .byte_4(b4),
    .valid_1(v1), .valid_2(v2), .valid_3(v3), .valid_4(v4),
    .sync_1(s1), .sync_2(s2), .sync_3(s3), .sync_4(s4),
    .sel_req(sel_req), .sel_req_valid(sel_req_valid),
    .out_byte(out_byte), .out_valid(out_valid), .out_sync(out_sync),
    .active_ch(active_ch), .ch_locked(ch_locked),
    .switch_done(switch_done), .pkt_abort(pkt_abort)
  );

  always #5 clk = ~clk;

  function automatic int pos(input int c);
    return (cyc + off[c]) % 188;
  endfunction

  // Drive one byte on every channel, then sample 1 time unit after the edge
  task automatic tick();
    for (int c = 0; c < 4; c++) begin
      last_p[c] = pos(c);
      drv_s[c]  = en[c] && (last_p[c] == 0);
      if (!en[c])              drv_b[c] = 8'h00;
      else if (last_p[c] == 0) drv_b[c] = 8'h47;
      else                     drv_b[c] = 8'((c + 1) * 16 + last_p[c]);
    end
    b1 = drv_b[0]; b2 = drv_b[1]; b3 = drv_b[2]; b4 = drv_b[3];
    s1 = drv_s[0]; s2 = drv_s[1]; s3 = drv_s[2]; s4 = drv_s[3];
    v1 = 1'b1; v2 = 1'b1; v3 = 1'b1; v4 = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_to_boundary(input int c);
    do tick(); while (last_p[c] != 0);
  endtask

  task automatic tick_to_pos(input int c, input int p);
    while (pos(c) != p) tick();
  endtask

  task automatic wait_sig(input bit on_switch, output bit ok);
    int n = 0;
    do begin
      tick();
      n++;
    end while (((on_switch ? switch_done : out_valid) !== 1'b1) && n < 500);
    ok = ((on_switch ? switch_done : out_valid) === 1'b1);
  endtask

  task automatic wait_lock(input int c);
    int n = 0;
    while (ch_locked[c] !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (ch_locked[c] !== 1'b1) begin
      errors++;
      $display("FAIL lock_ch%0d: ch_locked=%b expected bit %0d set", c + 1, ch_locked, c);
    end
  endtask

  task automatic request(input logic [1:0] ch);
    sel_req = ch;
    sel_req_valid = 1'b1;
    tick();
    sel_req_valid = 1'b0;
  endtask

  // Reset, then acquire ch1 alone
  task automatic start_ch1();
    bit ok;
    rst = 1'b0;
    en  = '{1, 0, 0, 0};
    off = '{0, 60, 100, 40};
    tick(); tick();
    rst = 1'b1;
    wait_sig(1'b1, ok);
    checks++;
    if (!ok || active_ch !== 2'd0) begin
      errors++;
      $display("FAIL start_ch1: switch_done=%b active_ch=%0d expected 1/0", switch_done, active_ch);
    end
  endtask

  task automatic test_reset();
    en  = '{1, 1, 1, 1};
    off = '{0, 60, 100, 40};
    #1 rst = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_byte !== 8'h00 || out_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b byte=%h sync=%b expected 0/00/0", out_valid, out_byte, out_sync);
    end
    checks++;
    if (active_ch !== 2'd0) begin
      errors++;
      $display("FAIL reset_active: got %0d expected 0", active_ch);
    end
    checks++;
    if (ch_locked !== 4'b0000) begin
      errors++;
      $display("FAIL reset_locked: got %b expected 0000", ch_locked);
    end
    checks++;
    if (switch_done !== 1'b0 || pkt_abort !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: switch_done=%b pkt_abort=%b expected 0/0", switch_done, pkt_abort);
    end
  endtask

  task automatic test_lock_forward();
    int bad = 0;
    int pulses = 0;
    en = '{1, 0, 0, 0};
    tick_to_pos(0, 180);
    rst = 1'b1;
    tick_to_boundary(0);
    checks++;
    if (ch_locked !== 4'b0001 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL first_sync_locks: ch_locked=%b out_valid=%b expected 0001/0", ch_locked, out_valid);
    end
    repeat (187) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_sop_silent: %0d output bytes expected 0", bad);
    end
    tick();
    checks++;
    if (switch_done !== 1'b1 || out_valid !== 1'b1 || out_sync !== 1'b1 || out_byte !== 8'h47 || active_ch !== 2'd0) begin
      errors++;
      $display("FAIL first_forward: sd=%b v=%b s=%b byte=%h ch=%0d expected 1/1/1/47/0",
               switch_done, out_valid, out_sync, out_byte, active_ch);
    end
    bad = 0;
    repeat (10) begin
      tick();
      if (out_valid !== 1'b1 || out_byte !== drv_b[0]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mirror_ch1: %0d bytes differ expected 0", bad);
    end
    repeat (200) begin
      tick();
      if (switch_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL switch_once: %0d extra switch_done pulses expected 0", pulses);
    end
  endtask

  task automatic test_request_switch();
    int bad = 0;
    bit ok;
    start_ch1();
    en[2] = 1'b1;
    wait_lock(2);
    tick_to_pos(0, 50);
    request(2'd2);
    do begin
      tick();
      if (last_p[0] != 0 && (out_valid !== 1'b1 || out_byte !== drv_b[0])) bad++;
    end while (last_p[0] != 0);
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ch1_runs_to_end: %0d bytes differ expected 0", bad);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ch1_sync_dropped: out_valid=%b expected 0", out_valid);
    end
    wait_sig(1'b0, ok);
    checks++;
    if (!ok || out_sync !== 1'b1 || switch_done !== 1'b1 || active_ch !== 2'd2 || last_p[2] != 0) begin
      errors++;
      $display("FAIL resume_ch3: v=%b s=%b sd=%b ch=%0d expected 1/1/1/2 at ch3 sync",
               out_valid, out_sync, switch_done, active_ch);
    end
    bad = 0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b1 || out_byte !== drv_b[2]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mirror_ch3: %0d bytes differ expected 0", bad);
    end
  endtask

  task automatic test_failover();
    bit ok;
    start_ch1();
    en[1] = 1'b1;
    wait_lock(1);
    tick_to_boundary(0);
    en[0] = 1'b0;
    repeat (375) tick();
    checks++;
    if (ch_locked[0] !== 1'b1) begin
      errors++;
      $display("FAIL lock_held_375: ch_locked[0]=%b expected 1", ch_locked[0]);
    end
    tick();
    checks++;
    if (ch_locked[0] !== 1'b0 || out_valid !== 1'b1 || pkt_abort !== 1'b0) begin
      errors++;
      $display("FAIL lock_lost_376: locked=%b v=%b abort=%b expected 0/1/0", ch_locked[0], out_valid, pkt_abort);
    end
    tick();
    checks++;
    if (pkt_abort !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL pkt_abort: abort=%b v=%b expected 1/0", pkt_abort, out_valid);
    end
    tick();
    checks++;
    if (pkt_abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse_width: abort=%b expected 0", pkt_abort);
    end
    wait_sig(1'b1, ok);
    checks++;
    if (!ok || active_ch !== 2'd1 || out_sync !== 1'b1 || last_p[1] != 0) begin
      errors++;
      $display("FAIL failover_ch2: sd=%b ch=%0d s=%b expected 1/1/1 at ch2 sync", switch_done, active_ch, out_sync);
    end
  endtask

  task automatic test_unlocked_request();
    bit ok;
    start_ch1();
    tick_to_pos(0, 20);
    request(2'd3);
    tick_to_boundary(0);
    checks++;
    if (out_valid !== 1'b1 || out_sync !== 1'b1 || switch_done !== 1'b0 || active_ch !== 2'd0) begin
      errors++;
      $display("FAIL unlocked_req_stays: v=%b s=%b sd=%b ch=%0d expected 1/1/0/0",
               out_valid, out_sync, switch_done, active_ch);
    end
    en[3] = 1'b1;
    wait_lock(3);
    tick_to_boundary(0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL late_lock_drop: out_valid=%b expected 0", out_valid);
    end
    wait_sig(1'b0, ok);
    checks++;
    if (!ok || switch_done !== 1'b1 || active_ch !== 2'd3 || last_p[3] != 0) begin
      errors++;
      $display("FAIL late_lock_switch: sd=%b ch=%0d expected 1/3 at ch4 sync", switch_done, active_ch);
    end
  endtask

  task automatic test_latest_request();
    bit ok;
    start_ch1();
    en[1] = 1'b1;
    en[3] = 1'b1;
    wait_lock(1);
    wait_lock(3);
    tick_to_pos(0, 30);
    request(2'd1);
    tick_to_pos(0, 60);
    request(2'd3);
    tick_to_boundary(0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL two_req_drop: out_valid=%b expected 0", out_valid);
    end
    wait_sig(1'b0, ok);
    checks++;
    if (!ok || switch_done !== 1'b1 || active_ch !== 2'd3 || last_p[3] != 0) begin
      errors++;
      $display("FAIL latest_wins: sd=%b ch=%0d expected 1/3 at ch4 sync", switch_done, active_ch);
    end
    tick_to_boundary(3);
    checks++;
    if (out_valid !== 1'b1 || out_sync !== 1'b1 || switch_done !== 1'b0) begin
      errors++;
      $display("FAIL pend_cleared: v=%b s=%b sd=%b expected 1/1/0", out_valid, out_sync, switch_done);
    end
  endtask

  task automatic test_reset_mid_forward();
    bit ok;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_forward: out_valid=%b expected 1", out_valid);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_byte !== 8'h00 || active_ch !== 2'd0 || ch_locked !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: v=%b byte=%h ch=%0d locked=%b expected 0/00/0/0000",
               out_valid, out_byte, active_ch, ch_locked);
    end
    en = '{1, 0, 0, 0};
    tick(); tick(); tick();
    rst = 1'b1;
    wait_sig(1'b1, ok);
    checks++;
    if (!ok || active_ch !== 2'd0 || ch_locked !== 4'b0001 || out_byte !== 8'h47) begin
      errors++;
      $display("FAIL reacquire: sd=%b ch=%0d locked=%b byte=%h expected 1/0/0001/47",
               switch_done, active_ch, ch_locked, out_byte);
    end
  endtask

  initial begin
    test_reset();
    test_lock_forward();
    test_request_switch();
    test_failover();
    test_unlocked_request();
    test_latest_request();
    test_reset_mid_forward();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
